// File: rtl/tone_arb_pkg.sv
// tone_arb_pkg: shared widths, owner encodings and arbiter state enum
package tone_arb_pkg;
    localparam int DIV_W = 22;
    localparam int AMP_W = 16;
    localparam int LEN_W = 5;
    localparam logic [1:0] OWN_BGM  = 2'd0;
    localparam logic [1:0] OWN_SFX0 = 2'd1;
    localparam logic [1:0] OWN_SFX1 = 2'd2;
    localparam logic [1:0] OWN_GAP  = 2'd3;
    // state codes equal the owner codes so owner is the state register itself
    typedef enum logic [1:0] {
        ST_BGM  = OWN_BGM,
        ST_SFX0 = OWN_SFX0,
        ST_SFX1 = OWN_SFX1,
        ST_GAP  = OWN_GAP
    } state_t;
endpackage

// File: rtl/tone_arbiter_if.sv
// tone_arbiter_if: melody/effect request bus and tone outputs of the arbiter
interface tone_arbiter_if;
    import tone_arb_pkg::*;
    logic             tick;
    logic [DIV_W-1:0] bgm_div;
    logic [AMP_W-1:0] bgm_amp;
    logic [1:0]       sfx_req;
    logic [DIV_W-1:0] sfx0_div;
    logic [DIV_W-1:0] sfx1_div;
    logic [AMP_W-1:0] sfx0_amp;
    logic [AMP_W-1:0] sfx1_amp;
    logic [LEN_W-1:0] sfx0_len;
    logic [LEN_W-1:0] sfx1_len;
    logic [1:0]       sfx_ack;
    logic [DIV_W-1:0] note_div;
    logic [AMP_W-1:0] amp_pos;
    logic [AMP_W-1:0] amp_neg;
    logic [1:0]       owner;
    logic             busy;
    modport master (
        output tick, bgm_div, bgm_amp, sfx_req, sfx0_div, sfx1_div, sfx0_amp, sfx1_amp, sfx0_len, sfx1_len,
        input  sfx_ack, note_div, amp_pos, amp_neg, owner, busy
    );
    modport slave (
        input  tick, bgm_div, bgm_amp, sfx_req, sfx0_div, sfx1_div, sfx0_amp, sfx1_amp, sfx0_len, sfx1_len,
        output sfx_ack, note_div, amp_pos, amp_neg, owner, busy
    );
endinterface

// File: rtl/tone_arb_timer.sv
// tone_arb_timer: effect beat counter; load (len 0 clamped to 1) beats decrement, done on the final beat
module tone_arb_timer
    import tone_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [LEN_W-1:0] len,
    output logic             done
);
    logic [LEN_W-1:0] cnt;

    // load outranks dec so a beat coinciding with a grant does not count
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= (len == '0) ? LEN_W'(1) : len;
        else if (dec && cnt != '0) cnt <= cnt - LEN_W'(1);
    end

    assign done = dec && cnt <= LEN_W'(1);
endmodule

// File: rtl/tone_arbiter.sv
// tone_arbiter: shares one tone generator between BGM and two prioritised sound effects
// TONE_ARB_GAP_EN adds a one-beat silent GAP after each effect that ends with nothing pending
module tone_arbiter
    import tone_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    tone_arbiter_if.slave bus
);
    state_t           state, state_nx;
    logic [1:0]       pend, req, gnt;
    logic             open_g, in_sfx, done;
    logic [DIV_W-1:0] cap_div;
    logic [AMP_W-1:0] cap_amp;
    logic [LEN_W-1:0] ld_len;

    // requests seen during reset never reach pending or the grant logic
    assign req    = rst ? 2'b00 : pend | bus.sfx_req;
    assign in_sfx = state == ST_SFX0 || state == ST_SFX1;
    assign ld_len = gnt[1] ? bus.sfx1_len : bus.sfx0_len;

    always_comb begin
        open_g = state == ST_BGM || state == ST_GAP || done || (state == ST_SFX0 && req[1]);
        gnt = !open_g ? 2'b00 : req[1] ? 2'b10 : req[0] ? 2'b01 : 2'b00;
`ifdef TONE_ARB_GAP_EN
        state_nx = gnt[1] ? ST_SFX1 : gnt[0] ? ST_SFX0 : done ? ST_GAP :
                   (state == ST_GAP && bus.tick) ? ST_BGM : state;
`else
        state_nx = gnt[1] ? ST_SFX1 : gnt[0] ? ST_SFX0 : done ? ST_BGM : state;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_BGM;
        else state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend         <= '0;
            cap_div      <= '0;
            cap_amp      <= '0;
            bus.note_div <= '0;
            bus.amp_pos  <= '0;
        end else begin
            pend <= req & ~gnt;
            if (|gnt) begin
                cap_div <= gnt[1] ? bus.sfx1_div : bus.sfx0_div;
                cap_amp <= gnt[1] ? bus.sfx1_amp : bus.sfx0_amp;
            end
            bus.note_div <= state == ST_BGM ? bus.bgm_div : in_sfx ? cap_div : '0;
            bus.amp_pos  <= state == ST_BGM ? bus.bgm_amp : in_sfx ? cap_amp : '0;
        end
    end

    tone_arb_timer u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (|gnt),
        .dec  (in_sfx && bus.tick),
        .len  (ld_len),
        .done (done)
    );

    assign bus.sfx_ack = gnt;
    assign bus.amp_neg = -bus.amp_pos;
    assign bus.owner   = state;
    assign bus.busy    = state != ST_BGM;
endmodule

// File: tb/tb_tone_arbiter.sv
// tb_tone_arbiter: directed scenarios plus randomized run against a beat-level reference model
module tb_tone_arbiter;
    import tone_arb_pkg::*;
`ifdef TONE_ARB_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    tone_arbiter_if bus();
    tone_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    int               m_own = 0;
    int               m_left = 0;
    logic [1:0]       m_pend = '0;
    logic [DIV_W-1:0] m_div = '0;
    logic [DIV_W-1:0] m_note = '0;
    logic [AMP_W-1:0] m_samp = '0;
    logic [AMP_W-1:0] m_amp = '0;

    // one clock of the reference: returns this cycle's grant and advances the model past the edge
    task automatic model_step(output logic [1:0] ack);
        logic [1:0] want;
        int who;
        bit playing, ending, may;
        ack = 2'b00;
        if (rst) begin
            m_own = 0; m_left = 0; m_pend = '0; m_note = '0; m_amp = '0;
        end else begin
            m_note = (m_own == 0) ? bus.bgm_div : (m_own == 3) ? '0 : m_div;
            m_amp  = (m_own == 0) ? bus.bgm_amp : (m_own == 3) ? '0 : m_samp;
            want = m_pend | bus.sfx_req;
            who = want[1] ? 1 : want[0] ? 0 : -1;
            playing = m_own == 1 || m_own == 2;
            ending = playing && bus.tick && m_left == 1;
            may = !playing || ending || (m_own == 1 && who == 1);
            if (may && who >= 0) begin
                ack[who] = 1'b1;
                m_pend = want & ~ack;
                m_own = who + 1;
                m_div = (who == 1) ? bus.sfx1_div : bus.sfx0_div;
                m_samp = (who == 1) ? bus.sfx1_amp : bus.sfx0_amp;
                m_left = (who == 1) ? int'(bus.sfx1_len) : int'(bus.sfx0_len);
                if (m_left == 0) m_left = 1;
            end else begin
                m_pend = want;
                if (ending) m_own = GAP_EN ? 3 : 0;
                else if (playing && bus.tick) m_left = m_left - 1;
                else if (m_own == 3 && bus.tick) m_own = 0;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk); rst = 1'b1; bus.sfx_req = 2'b11; bus.tick = 1'b1; bus.bgm_div = 22'd5; bus.bgm_amp = 16'd9; #1;
        n_checks++; if (bus.sfx_ack !== 2'b00) begin n_fail++; $display("FAIL rst_ack got=%b exp=00", bus.sfx_ack); end
        @(negedge clk); #1;
        n_checks++; if (bus.note_div !== 22'd0) begin n_fail++; $display("FAIL rst_note got=%0d exp=0", bus.note_div); end
        n_checks++; if (bus.amp_pos !== 16'd0 || bus.amp_neg !== 16'd0) begin n_fail++; $display("FAIL rst_amp got=%h/%h exp=0/0", bus.amp_pos, bus.amp_neg); end
        n_checks++; if (bus.owner !== 2'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_owner got=%0d/%b exp=0/0", bus.owner, bus.busy); end
        @(negedge clk); rst = 1'b0; bus.sfx_req = 2'b00; bus.tick = 1'b0; #1;
        n_checks++; if (bus.sfx_ack !== 2'b00) begin n_fail++; $display("FAIL rst_discard got=%b exp=00", bus.sfx_ack); end
        @(negedge clk); #1;
        n_checks++; if (bus.owner !== 2'd0) begin n_fail++; $display("FAIL rst_discard_owner got=%0d exp=0", bus.owner); end
    endtask

    task automatic test_bgm_idle;
        @(negedge clk); bus.bgm_div = 22'd127511; bus.bgm_amp = 16'h8fff; #1;
        @(negedge clk); #1;
        n_checks++; if (bus.note_div !== 22'd127511) begin n_fail++; $display("FAIL bgm_note got=%0d exp=127511", bus.note_div); end
        n_checks++; if (bus.amp_pos !== 16'h8fff) begin n_fail++; $display("FAIL bgm_amp got=%h exp=8fff", bus.amp_pos); end
        n_checks++; if (bus.amp_neg !== 16'h7001) begin n_fail++; $display("FAIL bgm_neg got=%h exp=7001", bus.amp_neg); end
        n_checks++; if (bus.owner !== 2'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL bgm_owner got=%0d/%b exp=0/0", bus.owner, bus.busy); end
    endtask

    task automatic test_sfx_gap;
        int n_sfx = 0;
        int n_gap = 0;
        @(negedge clk); bus.sfx0_div = 22'd113636; bus.sfx0_amp = 16'h1000; bus.sfx0_len = 5'd3; bus.sfx_req = 2'b01; bus.tick = 1'b0; #1;
        n_checks++; if (bus.sfx_ack !== 2'b01) begin n_fail++; $display("FAIL sfx_ack got=%b exp=01", bus.sfx_ack); end
        for (int c = 0; c < 45; c++) begin
            @(negedge clk); bus.sfx_req = 2'b00; bus.tick = (c % 10 == 9); #1;
            if (bus.owner === 2'd1) n_sfx++;
            if (bus.owner === 2'd3) n_gap++;
            if (c == 0) begin
                n_checks++; if (bus.sfx_ack !== 2'b00 || bus.owner !== 2'd1) begin n_fail++; $display("FAIL sfx_enter got=%b/%0d exp=00/1", bus.sfx_ack, bus.owner); end
            end
            if (c == 1) begin
                n_checks++; if (bus.note_div !== 22'd113636) begin n_fail++; $display("FAIL sfx_note got=%0d exp=113636", bus.note_div); end
            end
            if (c == 29) begin
                n_checks++; if (bus.owner !== 2'd1 || bus.amp_neg !== 16'hf000) begin n_fail++; $display("FAIL sfx_last_beat got=%0d/%h exp=1/f000", bus.owner, bus.amp_neg); end
            end
            if (c == 30) begin
                n_checks++; if (bus.owner !== (GAP_EN ? 2'd3 : 2'd0) || bus.busy !== GAP_EN) begin n_fail++; $display("FAIL sfx_exit got=%0d/%b exp=%0d/%b", bus.owner, bus.busy, GAP_EN ? 3 : 0, GAP_EN); end
            end
            if (c == 31) begin
                n_checks++; if (bus.note_div !== (GAP_EN ? 22'd0 : 22'd127511)) begin n_fail++; $display("FAIL sfx_after_note got=%0d exp=%0d", bus.note_div, GAP_EN ? 0 : 127511); end
            end
            if (c == 40) begin
                n_checks++; if (bus.owner !== 2'd0) begin n_fail++; $display("FAIL gap_leave got=%0d exp=0", bus.owner); end
            end
            if (c == 41) begin
                n_checks++; if (bus.note_div !== 22'd127511) begin n_fail++; $display("FAIL bgm_resume got=%0d exp=127511", bus.note_div); end
            end
        end
        n_checks++; if (n_sfx != 30) begin n_fail++; $display("FAIL sfx_duration got=%0d exp=30", n_sfx); end
        n_checks++; if (n_gap != (GAP_EN ? 10 : 0)) begin n_fail++; $display("FAIL gap_duration got=%0d exp=%0d", n_gap, GAP_EN ? 10 : 0); end
        bus.tick = 1'b0;
    endtask

    task automatic test_preempt;
        @(negedge clk); bus.sfx0_len = 5'd5; bus.sfx_req = 2'b01; bus.tick = 1'b0; #1;
        @(negedge clk); bus.sfx_req = 2'b00; #1;
        n_checks++; if (bus.owner !== 2'd1) begin n_fail++; $display("FAIL pre_sfx0 got=%0d exp=1", bus.owner); end
        @(negedge clk); #1;
        @(negedge clk); bus.sfx_req = 2'b10; bus.sfx1_div = 22'd200000; bus.sfx1_amp = 16'h0100; bus.sfx1_len = 5'd1; #1;
        n_checks++; if (bus.sfx_ack !== 2'b10) begin n_fail++; $display("FAIL pre_ack got=%b exp=10", bus.sfx_ack); end
        @(negedge clk); bus.sfx_req = 2'b00; #1;
        n_checks++; if (bus.owner !== 2'd2 || bus.sfx_ack !== 2'b00) begin n_fail++; $display("FAIL pre_owner got=%0d/%b exp=2/00", bus.owner, bus.sfx_ack); end
        @(negedge clk); #1;
        n_checks++; if (bus.note_div !== 22'd200000) begin n_fail++; $display("FAIL pre_note got=%0d exp=200000", bus.note_div); end
        @(negedge clk); bus.tick = 1'b1; #1;
        n_checks++; if (bus.sfx_ack !== 2'b00) begin n_fail++; $display("FAIL pre_no_resume_ack got=%b exp=00", bus.sfx_ack); end
        @(negedge clk); bus.tick = 1'b0; #1;
        n_checks++; if (bus.owner !== (GAP_EN ? 2'd3 : 2'd0)) begin n_fail++; $display("FAIL pre_no_resume got=%0d exp=%0d", bus.owner, GAP_EN ? 3 : 0); end
        @(negedge clk); bus.tick = 1'b1;
        @(negedge clk); bus.tick = 1'b0; #1;
        n_checks++; if (bus.owner !== 2'd0) begin n_fail++; $display("FAIL pre_settle got=%0d exp=0", bus.owner); end
    endtask

    task automatic test_simultaneous;
        @(negedge clk); bus.sfx0_len = 5'd2; bus.sfx1_len = 5'd1; bus.sfx0_div = 22'd1111; bus.sfx1_div = 22'd2222; bus.sfx_req = 2'b11; #1;
        n_checks++; if (bus.sfx_ack !== 2'b10) begin n_fail++; $display("FAIL sim_ack1 got=%b exp=10", bus.sfx_ack); end
        @(negedge clk); bus.sfx_req = 2'b00; #1;
        n_checks++; if (bus.owner !== 2'd2 || bus.sfx_ack !== 2'b00) begin n_fail++; $display("FAIL sim_owner2 got=%0d/%b exp=2/00", bus.owner, bus.sfx_ack); end
        @(negedge clk); bus.tick = 1'b1; #1;
        n_checks++; if (bus.sfx_ack !== 2'b01) begin n_fail++; $display("FAIL sim_ack0 got=%b exp=01", bus.sfx_ack); end
        @(negedge clk); bus.tick = 1'b0; #1;
        n_checks++; if (bus.owner !== 2'd1) begin n_fail++; $display("FAIL sim_no_gap got=%0d exp=1", bus.owner); end
        @(negedge clk); #1;
        n_checks++; if (bus.note_div !== 22'd1111) begin n_fail++; $display("FAIL sim_note0 got=%0d exp=1111", bus.note_div); end
        @(negedge clk); bus.tick = 1'b1;
        @(negedge clk); bus.tick = 1'b0; #1;
        n_checks++; if (bus.owner !== 2'd1) begin n_fail++; $display("FAIL sim_len2 got=%0d exp=1", bus.owner); end
        @(negedge clk); bus.tick = 1'b1;
        @(negedge clk); bus.tick = 1'b0; #1;
        n_checks++; if (bus.owner !== (GAP_EN ? 2'd3 : 2'd0)) begin n_fail++; $display("FAIL sim_end got=%0d exp=%0d", bus.owner, GAP_EN ? 3 : 0); end
        @(negedge clk); bus.tick = 1'b1;
        @(negedge clk); bus.tick = 1'b0;
    endtask

    task automatic test_len0;
        @(negedge clk); bus.sfx0_len = 5'd0; bus.sfx_req = 2'b01; bus.tick = 1'b1; #1;
        n_checks++; if (bus.sfx_ack !== 2'b01) begin n_fail++; $display("FAIL len0_ack got=%b exp=01", bus.sfx_ack); end
        @(negedge clk); bus.sfx_req = 2'b00; bus.tick = 1'b0; #1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (bus.owner !== 2'd1) begin n_fail++; $display("FAIL len0_hold got=%0d exp=1", bus.owner); end
        @(negedge clk); bus.tick = 1'b1;
        @(negedge clk); bus.tick = 1'b0; #1;
        n_checks++; if (bus.owner !== (GAP_EN ? 2'd3 : 2'd0)) begin n_fail++; $display("FAIL len0_one_beat got=%0d exp=%0d", bus.owner, GAP_EN ? 3 : 0); end
        @(negedge clk); bus.tick = 1'b1;
        @(negedge clk); bus.tick = 1'b0;
    endtask

    task automatic test_rst_mid;
        @(negedge clk); bus.sfx1_len = 5'd5; bus.sfx1_div = 22'd3333; bus.sfx1_amp = 16'h4000; bus.sfx_req = 2'b10; #1;
        n_checks++; if (bus.sfx_ack !== 2'b10) begin n_fail++; $display("FAIL rmid_ack got=%b exp=10", bus.sfx_ack); end
        @(negedge clk); bus.sfx_req = 2'b01; #1;
        n_checks++; if (bus.owner !== 2'd2 || bus.sfx_ack !== 2'b00) begin n_fail++; $display("FAIL rmid_queue got=%0d/%b exp=2/00", bus.owner, bus.sfx_ack); end
        @(negedge clk); bus.sfx_req = 2'b00; #1;
        n_checks++; if (bus.note_div !== 22'd3333) begin n_fail++; $display("FAIL rmid_note got=%0d exp=3333", bus.note_div); end
        @(negedge clk); rst = 1'b1; bus.sfx_req = 2'b11; #1;
        n_checks++; if (bus.sfx_ack !== 2'b00) begin n_fail++; $display("FAIL rmid_rst_ack got=%b exp=00", bus.sfx_ack); end
        @(negedge clk); rst = 1'b0; bus.sfx_req = 2'b00; #1;
        n_checks++; if (bus.note_div !== 22'd0 || bus.amp_pos !== 16'd0 || bus.amp_neg !== 16'd0) begin n_fail++; $display("FAIL rmid_zero got=%0d/%h/%h exp=0/0/0", bus.note_div, bus.amp_pos, bus.amp_neg); end
        n_checks++; if (bus.owner !== 2'd0 || bus.busy !== 1'b0 || bus.sfx_ack !== 2'b00) begin n_fail++; $display("FAIL rmid_owner got=%0d/%b/%b exp=0/0/00", bus.owner, bus.busy, bus.sfx_ack); end
        @(negedge clk); #1;
        n_checks++; if (bus.owner !== 2'd0 || bus.sfx_ack !== 2'b00) begin n_fail++; $display("FAIL rmid_no_replay got=%0d/%b exp=0/00", bus.owner, bus.sfx_ack); end
    endtask

    task automatic test_random;
        logic [1:0] ack_exp;
        int neg;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = (i < 2) || ($urandom_range(0, 299) == 0);
            bus.tick = ($urandom_range(0, 3) == 0);
            bus.sfx_req = {1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0)};
            bus.bgm_div = 22'($urandom);
            bus.bgm_amp = 16'($urandom);
            bus.sfx0_div = 22'($urandom);
            bus.sfx1_div = 22'($urandom);
            bus.sfx0_amp = 16'($urandom);
            bus.sfx1_amp = 16'($urandom);
            bus.sfx0_len = 5'($urandom_range(0, 6));
            bus.sfx1_len = 5'($urandom_range(0, 6));
            #1;
            if (i > 0) begin
                neg = (65536 - int'(m_amp)) % 65536;
                n_checks++; if (bus.owner !== 2'(m_own) || bus.busy !== (m_own != 0)) begin n_fail++; $display("FAIL rnd_owner cyc=%0d got=%0d/%b exp=%0d/%b", i, bus.owner, bus.busy, m_own, m_own != 0); end
                n_checks++; if (bus.note_div !== m_note) begin n_fail++; $display("FAIL rnd_note cyc=%0d got=%0d exp=%0d", i, bus.note_div, m_note); end
                n_checks++; if (bus.amp_pos !== m_amp || bus.amp_neg !== 16'(neg)) begin n_fail++; $display("FAIL rnd_amp cyc=%0d got=%h/%h exp=%h/%h", i, bus.amp_pos, bus.amp_neg, m_amp, 16'(neg)); end
            end
            model_step(ack_exp);
            n_checks++; if (bus.sfx_ack !== ack_exp) begin n_fail++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", i, bus.sfx_ack, ack_exp); end
        end
        @(negedge clk); rst = 1'b0; bus.sfx_req = 2'b00; bus.tick = 1'b0;
    endtask

    initial begin
        bus.tick = 1'b0; bus.sfx_req = 2'b00;
        bus.bgm_div = '0; bus.bgm_amp = '0;
        bus.sfx0_div = '0; bus.sfx1_div = '0; bus.sfx0_amp = '0; bus.sfx1_amp = '0;
        bus.sfx0_len = '0; bus.sfx1_len = '0;
        test_reset;
        test_bgm_idle;
        test_sfx_gap;
        test_preempt;
        test_simultaneous;
        test_len0;
        test_rst_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tone_arbiter.md
TONE_ARBITER -- requirements
Module: tone_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  system clock; sole clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: tick  input  1  one-cycle beat strobe from the beat divider.
REQ-004 SHALL have ports: bgm_div  input  22 and bgm_amp  input  16, carrying the background-melody note divider and amplitude; 0 means rest.
REQ-005 SHALL have ports: sfx_req  input  2  per-requester request pulses; bit 1 is highest priority.
REQ-006 SHALL have ports: sfx0_div, sfx1_div  input  22; sfx0_amp, sfx1_amp  input  16; sfx0_len, sfx1_len  input  5 (length in beats).
REQ-007 SHALL have port: sfx_ack  output  2  one-cycle grant pulse per requester.
REQ-008 SHALL have ports: note_div  output  22  to tone generator; amp_pos  output  16; amp_neg  output  16.
REQ-009 SHALL have ports: owner  output  2  (0=BGM, 1=SFX0, 2=SFX1, 3=GAP); busy  output  1, high whenever owner is not BGM.

Function
REQ-010 SHALL implement the states BGM, SFX0, SFX1 and GAP.
REQ-011 SHALL set pending[i] on any cycle with sfx_req[i]=1, and clear it in the cycle the request is granted.
REQ-012 Grant from BGM or GAP: highest pending wins; SHALL capture that requester's div, amp and len, pulse its sfx_ack for 1 cycle, and enter SFXi next cycle.
REQ-013 In SFX0, a pending SFX1 SHALL preempt immediately via REQ-012. SFX0 is then abandoned, not resumed.
REQ-014 In SFX1, new requests SHALL stay pending. sfx_req[1] during SFX1 SHALL queue one replay.
REQ-015 Beat counter loads captured len. A captured len of 0 SHALL be clamped to 1. The counter decrements on tick, and at 0 SHALL exit SFXi.
REQ-016 On exit from SFXi: if a request is pending, SHALL grant it directly; otherwise SHALL go to GAP (when the macro is defined) or BGM.
REQ-017 GAP SHALL output silence for exactly one full tick interval: enter at exit, leave at the next tick.
REQ-018 Output mux SHALL be registered, with 1-cycle latency from state or input to note_div/amp_pos.
REQ-019 Per state, outputs SHALL be: BGM passes bgm_div/bgm_amp live; SFXi drives the captured values; GAP drives 0/0.
REQ-020 SHALL drive amp_neg as the 16-bit two's complement of amp_pos, wrapping so that 0 gives 0.
REQ-021 tick coincident with a grant SHALL NOT decrement the newly loaded counter.
REQ-022 Simultaneous sfx_req bits SHALL grant bit 1 first; bit 0 stays pending.

Reset
REQ-023 While rst=1, SHALL hold: state BGM, pending=0, counter=0, sfx_ack=0, note_div=0, amp_pos=0, amp_neg=0, owner=0, busy=0.
REQ-024 Requests arriving during rst SHALL be discarded.
REQ-025 rst asserted mid-effect SHALL abort that effect with no ack replay.

Configuration
REQ-026 Macro TONE_ARB_GAP_EN SHALL control the GAP state.
REQ-027 With TONE_ARB_GAP_EN defined, SHALL insert GAP per REQ-016/017.
REQ-028 With TONE_ARB_GAP_EN undefined, GAP SHALL be unreachable: effect exit goes straight to BGM, and owner never equals 3.

Structure
REQ-029 Package tone_arb_pkg SHALL hold the state enum, DIV_W=22, AMP_W=16, LEN_W=5, and the owner encodings.
REQ-030 SHALL contain one sub-module tone_arb_timer, holding the load/decrement/clamp beat counter with a done flag.

Verification
REQ-031 Reset then idle: bgm_div=127511, bgm_amp=16'h8fff -> one cycle later note_div=127511, amp_neg=16'h7001, owner=0.
REQ-032 sfx_req=01 with len=3 and div=113636, tick every 10 cycles -> sfx_ack=01 for 1 cycle; note_div=113636 for 3 ticks, then GAP 0 for 1 tick, then BGM.
REQ-033 SFX0 active, then sfx_req=10 -> ack[1] pulse; owner becomes 2 the next cycle and SFX0 is not resumed.
REQ-034 sfx_req=11 in the same cycle -> SFX1 served first, then SFX0 directly with no GAP between.
REQ-035 len=0 -> plays exactly 1 tick. rst pulsed mid-SFX1 -> all outputs 0 and owner=0 on the next cycle.
REQ-036 With the macro undefined, rerun REQ-032 -> BGM resumes immediately and owner is never 3.
